// File: rtl/puf_uart_pkg.sv
// Shared types and constants for the uart-to-PUF challenge/response sequencer.
package puf_uart_pkg;

  localparam int CHAL_W = 64;
  localparam int SYM_W  = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    WAIT_PUF = 3'd2,
    TX_REQ   = 3'd3,
    TX_BUSY  = 3'd4
  } state_e;

endpackage

// File: rtl/puf_uart_timer.sv
// Clearable up-counter whose terminal-count flag fires on the last cycle of a limit-cycle window.
module puf_uart_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == (limit_i - W'(1)));

endmodule

// File: rtl/puf_uart_seq.sv
// Accepts uart challenge frames, launches the PUF, and streams the response back
// over the uart transmitter as 2-bit symbols, MSB first.
module puf_uart_seq
  import puf_uart_pkg::*;
#(
  parameter int RESP_W      = 8,
  parameter int PUF_TIMEOUT = 1024,
  parameter int TX_TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              received,
  input  logic [CHAL_W-1:0] rx_byte,
  input  logic              recv_error,
  input  logic              is_transmitting,
  output logic              transmit,
  output logic [SYM_W-1:0]  tx_bit,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              puf_start,
  input  logic              puf_done,
  input  logic [RESP_W-1:0] puf_response,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        drop_cnt
);

  localparam int NSYM  = RESP_W / SYM_W;
  localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int TMAX  = (PUF_TIMEOUT > TX_TIMEOUT) ? PUF_TIMEOUT : TX_TIMEOUT;
  localparam int TMR_W = $clog2(TMAX) + 1;

  state_e              state_q, state_d;
  logic [CHAL_W-1:0]   chal_q, chal_d;
  logic [RESP_W-1:0]   sh_q, sh_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                err_q, err_d;
  logic [7:0]          drop_q, drop_d;
  logic                tmr_inc_s, tmr_clr_s, tmr_tc_s;
  logic [TMR_W-1:0]    tmr_limit_s;

  // One timer serves both waits; the window length follows the state that owns it.
  assign tmr_limit_s = (state_q == TX_REQ) ? TMR_W'(TX_TIMEOUT) : TMR_W'(PUF_TIMEOUT);
  assign tmr_clr_s   = (state_d != state_q);

  puf_uart_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr_s),
    .inc_i   (tmr_inc_s),
    .limit_i (tmr_limit_s),
    .tc_o    (tmr_tc_s)
  );

  always_comb begin
    state_d   = state_q;
    chal_d    = chal_q;
    sh_d      = sh_q;
    idx_d     = idx_q;
    err_d     = err_q;
    drop_d    = drop_q;
    tmr_inc_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (received && !recv_error) begin
          chal_d  = rx_byte;
          state_d = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        state_d = WAIT_PUF;
      end
      WAIT_PUF: begin
        if (puf_done) begin
          sh_d    = puf_response;
          idx_d   = '0;
          state_d = TX_REQ;
        end else if (tmr_tc_s) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_inc_s = 1'b1;
        end
      end
      TX_REQ: begin
        if (is_transmitting) begin
          state_d = TX_BUSY;
        end else if (tmr_tc_s) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_inc_s = 1'b1;
        end
      end
      TX_BUSY: begin
        if (!is_transmitting) begin
          if (idx_q == IDX_W'(NSYM - 1)) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            sh_d    = sh_q << SYM_W;
            state_d = TX_REQ;
          end
        end else begin
          state_d = TX_BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A frame landing on the cycle we return to IDLE is still seen with state_q != IDLE.
    if (received && ((state_q != IDLE) || recv_error) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      chal_q  <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      chal_q  <= chal_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign transmit      = (state_q == TX_REQ);
  assign tx_bit        = sh_q[RESP_W-1 -: SYM_W];
  assign puf_start     = (state_q == LAUNCH);
  assign busy          = (state_q != IDLE);
  assign puf_challenge = chal_q;
  assign timeout_err   = err_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_puf_uart_seq.sv
// Directed bench for puf_uart_seq: normal path, timeouts, done/timeout race, dropping, async reset.
module tb_puf_uart_seq;

  logic        clk;
  logic        rst;
  logic        received;
  logic [63:0] rx_byte;
  logic        recv_error;
  logic        is_transmitting;
  logic        transmit;
  logic [1:0]  tx_bit;
  logic [63:0] puf_challenge;
  logic        puf_start;
  logic        puf_done;
  logic [7:0]  puf_response;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  drop_cnt;

  int total;
  int bad;

  puf_uart_seq #(
    .RESP_W      (8),
    .PUF_TIMEOUT (16),
    .TX_TIMEOUT  (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .received        (received),
    .rx_byte         (rx_byte),
    .recv_error      (recv_error),
    .is_transmitting (is_transmitting),
    .transmit        (transmit),
    .tx_bit          (tx_bit),
    .puf_challenge   (puf_challenge),
    .puf_start       (puf_start),
    .puf_done        (puf_done),
    .puf_response    (puf_response),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .drop_cnt        (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_transmit", 64'(transmit), 64'(1'b0));
    chk("rst_tx_bit", 64'(tx_bit), 64'(2'b00));
    chk("rst_challenge", puf_challenge, 64'h0);
    chk("rst_start", 64'(puf_start), 64'(1'b0));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_err", 64'(timeout_err), 64'(1'b0));
    chk("rst_drop", 64'(drop_cnt), 64'(8'd0));
    rst = 1'b0;
  endtask

  // exp_syms holds the four hand-written symbols, first symbol in bits [7:6].
  task automatic run_frame(input logic [63:0] chal, input logic [7:0] resp,
                           input logic [7:0] exp_syms, input int done_wait, input int drops);
    logic [7:0] syms;
    int         sent;
    syms     = exp_syms;
    sent     = 0;
    received = 1'b1;
    recv_error = 1'b0;
    rx_byte  = chal;
    tick();
    received = 1'b0;
    rx_byte  = 64'h0;
    chk("start_pulse", 64'(puf_start), 64'(1'b1));
    chk("challenge", puf_challenge, chal);
    tick();
    chk("start_single", 64'(puf_start), 64'(1'b0));
    repeat (done_wait - 1) tick();
    chk("pre_done_busy", 64'(busy), 64'(1'b1));
    chk("pre_done_err", 64'(timeout_err), 64'(1'b0));
    puf_done     = 1'b1;
    puf_response = resp;
    tick();
    puf_done     = 1'b0;
    puf_response = 8'h00;
    chk("post_done_err", 64'(timeout_err), 64'(1'b0));
    for (int s = 0; s < 4; s++) begin
      chk("transmit_req", 64'(transmit), 64'(1'b1));
      chk("tx_bit", 64'(tx_bit), 64'(syms[7:6]));
      is_transmitting = 1'b1;
      tick();
      chk("transmit_busy", 64'(transmit), 64'(1'b0));
      chk("tx_bit_hold", 64'(tx_bit), 64'(syms[7:6]));
      for (int c = 0; c < 4; c++) begin
        if ((c % 2 == 0) && (sent < drops)) begin
          received = 1'b1;
          rx_byte  = 64'hBAD0_BAD0_BAD0_BAD0;
          sent++;
        end else begin
          received = 1'b0;
        end
        tick();
      end
      received = 1'b0;
      rx_byte  = 64'h0;
      is_transmitting = 1'b0;
      tick();
      syms = syms << 2;
    end
    chk("busy_end", 64'(busy), 64'(1'b0));
    chk("transmit_end", 64'(transmit), 64'(1'b0));
    chk("chal_kept", puf_challenge, chal);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    received = 1'b0;
    rx_byte = 64'h0;
    recv_error = 1'b0;
    is_transmitting = 1'b0;
    puf_done = 1'b0;
    puf_response = 8'h00;
    do_reset();

    // Normal path: B4 -> 10 11 01 00.
    run_frame(64'hDEADBEEF_01234567, 8'hB4, {2'b10, 2'b11, 2'b01, 2'b00}, 10, 0);
    chk("t1_drop", 64'(drop_cnt), 64'(8'd0));

    // Race: done on the 16th (last) WAIT_PUF cycle; 69 -> 01 10 10 01.
    run_frame(64'h1111_2222_3333_4444, 8'h69, {2'b01, 2'b10, 2'b10, 2'b01}, 16, 0);
    chk("t6_err", 64'(timeout_err), 64'(1'b0));

    // PUF timeout, with a frame arriving on the expiry cycle.
    received = 1'b1;
    rx_byte  = 64'h00C0_FFEE_00C0_FFEE;
    tick();
    received = 1'b0;
    tick();
    for (int i = 1; i < 16; i++) begin
      chk("t2_no_tx", 64'(transmit), 64'(1'b0));
      tick();
    end
    chk("t2_err_c16", 64'(timeout_err), 64'(1'b0));
    chk("t2_busy_c16", 64'(busy), 64'(1'b1));
    received = 1'b1;
    rx_byte  = 64'h7777_7777_7777_7777;
    tick();
    received = 1'b0;
    rx_byte  = 64'h0;
    chk("t2_err", 64'(timeout_err), 64'(1'b1));
    chk("t2_idle", 64'(busy), 64'(1'b0));
    chk("t2_transmit", 64'(transmit), 64'(1'b0));
    chk("t2_edge_drop", 64'(drop_cnt), 64'(8'd1));
    chk("t2_chal", puf_challenge, 64'h00C0_FFEE_00C0_FFEE);

    do_reset();

    // Dropping: 3 frames while busy transmitting, then one error frame in IDLE.
    run_frame(64'h0123_4567_89AB_CDEF, 8'h1E, {2'b00, 2'b01, 2'b11, 2'b10}, 3, 3);
    chk("t3_drop3", 64'(drop_cnt), 64'(8'd3));
    received   = 1'b1;
    recv_error = 1'b1;
    rx_byte    = 64'hFFFF_0000_FFFF_0000;
    tick();
    received   = 1'b0;
    chk("t3_drop4", 64'(drop_cnt), 64'(8'd4));
    chk("t3_idle", 64'(busy), 64'(1'b0));
    chk("t3_chal", puf_challenge, 64'h0123_4567_89AB_CDEF);
    received = 1'b1;
    repeat (300) tick();
    received   = 1'b0;
    recv_error = 1'b0;
    rx_byte    = 64'h0;
    tick();
    chk("t3_sat", 64'(drop_cnt), 64'(8'd255));
    chk("t3_sat_idle", 64'(busy), 64'(1'b0));

    // TX stall: transmit must stay high for exactly 8 cycles.
    received = 1'b1;
    rx_byte  = 64'h5555_AAAA_5555_AAAA;
    tick();
    received = 1'b0;
    chk("t4_start", 64'(puf_start), 64'(1'b1));
    tick();
    puf_done     = 1'b1;
    puf_response = 8'hC3;
    tick();
    puf_done     = 1'b0;
    chk("t4_tx_bit", 64'(tx_bit), 64'(2'b11));
    for (int i = 0; i < 8; i++) begin
      chk("t4_transmit_hi", 64'(transmit), 64'(1'b1));
      chk("t4_err_lo", 64'(timeout_err), 64'(1'b0));
      tick();
    end
    chk("t4_transmit_lo", 64'(transmit), 64'(1'b0));
    chk("t4_err", 64'(timeout_err), 64'(1'b1));
    chk("t4_idle", 64'(busy), 64'(1'b0));

    // Async reset in TX_BUSY of the second symbol, between clock edges.
    received = 1'b1;
    rx_byte  = 64'h0F0F_0F0F_0F0F_0F0F;
    tick();
    received = 1'b0;
    tick();
    puf_done     = 1'b1;
    puf_response = 8'hAA;
    tick();
    puf_done = 1'b0;
    is_transmitting = 1'b1;
    tick();
    is_transmitting = 1'b0;
    tick();
    chk("t5_sym1_req", 64'(transmit), 64'(1'b1));
    is_transmitting = 1'b1;
    tick();
    chk("t5_pre_busy", 64'(busy), 64'(1'b1));
    chk("t5_pre_drop", 64'(drop_cnt), 64'(8'd255));
    #2;
    rst = 1'b1;
    #1;
    chk("t5_transmit", 64'(transmit), 64'(1'b0));
    chk("t5_busy", 64'(busy), 64'(1'b0));
    chk("t5_drop", 64'(drop_cnt), 64'(8'd0));
    chk("t5_err", 64'(timeout_err), 64'(1'b0));
    chk("t5_chal", puf_challenge, 64'h0);
    is_transmitting = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("t5_stay_idle", 64'(busy), 64'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
